switch_allocator: RTL and testbench
===================================

// Module: switch_allocator
// PURPOSE
//  Wormhole switch allocator for the 5-port mesh router (N=0,E=1,S=2,W=3,L=4).
//  Each output port is arbitrated by round-robin among the input buffers whose head flit routes to it.
//  Once a head flit wins an output, that output is locked to the winning input until its tail flit leaves.
//  Drives the crossbar selects and the input-buffer pops; respects the downstream buffer_on flow control.
// PARAMETERS
//  NUM_PORTS     5    router ports; fixed at 5, other values unsupported
//  PORT_W        3    width of a port index
//  LOCK_TIMEOUT  64   idle cycles tolerated on a locked output before lock_err sets (>=1)
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         asynchronous reset, active high
//  req_valid     in   5         bit i: input buffer i holds a flit at its head
//  req_port      in   15        [3i+2:3i] output port computed for input i's head flit (XY route)
//  req_is_head   in   5         bit i: input i's head flit is a head flit
//  req_is_tail   in   5         bit i: input i's head flit is a tail (head+tail = single-flit packet)
//  buffer_on_out in   5         bit o: downstream at output o can accept a flit this cycle
//  out_valid     out  5         bit o: crossbar drives a valid flit on output o this cycle
//  out_sel       out  15        [3o+2:3o] input index switched to output o (valid when out_valid[o])
//  in_pop        out  5         bit i: input buffer i dequeues its head flit this cycle
//  out_locked    out  5         bit o: output o is mid-packet (registered state)
//  lock_err      out  5         bit o: sticky; locked output o saw no progress for LOCK_TIMEOUT cycles
// BEHAVIOUR
//  Per-output state: IDLE or LOCKED(owner[2:0]); rr_ptr[2:0] per output; idle counter per output.
//  Reset (async): all outputs IDLE, rr_ptr=0, counters=0, lock_err=0. While rst=1: out_valid, in_pop,
//   out_locked, lock_err = 0; out_sel = 0.
//  Candidate i for output o: req_valid[i] & req_port[i]==o & req_port[i]<5.
//   req_port values 5..7 never match any output.
//  IDLE o: only candidates with req_is_head=1 are eligible.
//   If any are eligible and buffer_on_out[o]=1: winner = first eligible scanning rr_ptr, rr_ptr+1, ... mod 5.
//   Same cycle (combinational, zero latency): out_valid[o]=1, out_sel[o]=winner, in_pop[winner]=1.
//   Next state: LOCKED(winner) unless req_is_tail[winner]=1 (single flit), in which case stays IDLE.
//   rr_ptr <= winner+1 mod 5 only on a grant. If buffer_on_out[o]=0: no grant, state and rr_ptr held.
//  LOCKED(w) o: only input w is served; other inputs requesting o wait (no pop).
//   Forward when req_valid[w] & req_port[w]==o & buffer_on_out[o]: out_valid[o]=1, out_sel[o]=w, in_pop[w]=1.
//   Forward of a tail flit -> IDLE next cycle; rr_ptr <= w+1 mod 5.
//   A non-forwarding cycle (bubble or backpressure) holds the lock.
//   A head flit from w while locked is forwarded as body (no re-arbitration).
//  Each input routes to exactly one output, so at most one output grants an input per cycle.
//   in_pop[i] = OR over o of the grants to i.
//  Timeout: idle counter per output, cleared on every forward and on IDLE.
//   Increments each LOCKED cycle without a forward and saturates at LOCK_TIMEOUT.
//   Reaching LOCK_TIMEOUT sets lock_err[o], which stays set until rst. Allocation is unaffected.
//  Reset mid-packet: lock dropped immediately. The next flit from the former owner is a body flit and is
//   ineligible while IDLE, so upstream must flush; this is a documented system rule, not checked here.
//  Outputs are independent: up to 5 grants per cycle, one per output.
//  U-turns (req_port==own input index) are allowed.
// TESTING
//  1) Reset: rst=1 for 2 clks with all req_valid=1 -> out_valid=0, in_pop=0, out_locked=0, lock_err=0.
//  2) Contention: N,E,S,W all send head to L (port 4), buffer_on_out=5'h1F -> first grant N (sel=0).
//     4-flit packet locks L for 4 cycles; then E, then S, then W (rr order), each holding L until its tail.
//  3) Backpressure: locked to E (owner=1), buffer_on_out[4]=0 for 3 cycles.
//     -> out_valid[4]=0, in_pop=0, lock held. Releasing resumes with the next body flit, out_sel[4]=1.
//  4) Parallel: N->S, E->W, L->N simultaneously, single-flit packets, all buffer_on=1.
//     -> out_valid=5'b01101, in_pop=5'b10011, out_locked stays 0.
//  5) Timeout: LOCK_TIMEOUT=4, lock output E (1) to W then drop req_valid[3] for 4 cycles.
//     -> lock_err[1]=1 on the 4th idle cycle, stays 1 after the tail forwards, clears only on rst.
//  6) Async reset mid-packet: assert rst between clock edges while output 2 is LOCKED.
//     -> out_locked[2]=0 and in_pop=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/switch_allocator.sv
// Wormhole switch allocator for a 5-port mesh router: each output is won by a head flit
// through round-robin arbitration, then stays locked to that input until its tail leaves.
module switch_allocator #(
  parameter int NUM_PORTS    = 5,
  parameter int PORT_W       = 3,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*PORT_W-1:0]   req_port,
  input  logic [NUM_PORTS-1:0]          req_is_head,
  input  logic [NUM_PORTS-1:0]          req_is_tail,
  input  logic [NUM_PORTS-1:0]          buffer_on_out,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic [NUM_PORTS*PORT_W-1:0]   out_sel,
  output logic [NUM_PORTS-1:0]          in_pop,
  output logic [NUM_PORTS-1:0]          out_locked,
  output logic [NUM_PORTS-1:0]          lock_err
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int SUM_W = PORT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);

  function automatic logic [PORT_W-1:0] wrap_inc(input logic [PORT_W-1:0] p);
    return (p == PORT_W'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  // grant_flat[NUM_PORTS*o + i]: output o switches input i this cycle
  logic [NUM_PORTS*NUM_PORTS-1:0] grant_flat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_out
      logic                 locked_reg, locked_next;
      logic [PORT_W-1:0]    owner_reg, owner_next;
      logic [PORT_W-1:0]    rr_ptr_reg, rr_ptr_next;
      logic [CNT_W-1:0]     cnt_reg, cnt_next;
      logic                 err_reg, err_next;
      logic [NUM_PORTS-1:0] cand;
      logic [NUM_PORTS-1:0] grant;
      logic [PORT_W-1:0]    sel;
      logic [SUM_W-1:0]     sum;
      logic [PORT_W-1:0]    idx;
      logic                 fwd;
      logic                 found;

      // Ports 5..7 never equal an output index, so they drop out here.
      always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
          cand[i] = req_valid[i] && (req_port[PORT_W*i +: PORT_W] == PORT_W'(gi));
        end
      end

      always_comb begin
        grant       = '0;
        sel         = owner_reg;
        fwd         = 1'b0;
        found       = 1'b0;
        sum         = '0;
        idx         = '0;
        locked_next = locked_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        cnt_next    = cnt_reg;
        err_next    = err_reg;
        if (!locked_reg) begin
          cnt_next = '0;
          if (buffer_on_out[gi]) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
              sum = {1'b0, rr_ptr_reg} + SUM_W'(k);
              idx = (sum >= SUM_W'(NUM_PORTS)) ? PORT_W'(sum - SUM_W'(NUM_PORTS)) : PORT_W'(sum);
              if (!found && cand[idx] && req_is_head[idx]) begin
                found = 1'b1;
                sel   = idx;
              end
            end
          end
          if (found) begin
            fwd         = 1'b1;
            grant[sel]  = 1'b1;
            locked_next = !req_is_tail[sel];
            owner_next  = sel;
            rr_ptr_next = wrap_inc(sel);
          end
        end else begin
          if (cand[owner_reg] && buffer_on_out[gi]) begin
            fwd              = 1'b1;
            grant[owner_reg] = 1'b1;
            cnt_next         = '0;
            if (req_is_tail[owner_reg]) begin
              locked_next = 1'b0;
              rr_ptr_next = wrap_inc(owner_reg);
            end
          end else begin
            if (cnt_reg < CNT_MAX) cnt_next = cnt_reg + 1'b1;
            if (cnt_next == CNT_MAX) err_next = 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          locked_reg <= 1'b0;
          owner_reg  <= '0;
          rr_ptr_reg <= '0;
          cnt_reg    <= '0;
          err_reg    <= 1'b0;
        end else begin
          locked_reg <= locked_next;
          owner_reg  <= owner_next;
          rr_ptr_reg <= rr_ptr_next;
          cnt_reg    <= cnt_next;
          err_reg    <= err_next;
        end
      end

      // Combinational outputs are gated so an asserted reset silences them at once.
      assign out_valid[gi]                   = fwd & ~rst;
      assign out_sel[PORT_W*gi +: PORT_W]    = (fwd && !rst) ? sel : '0;
      assign out_locked[gi]                  = locked_reg & ~rst;
      assign lock_err[gi]                    = err_reg & ~rst;
      assign grant_flat[NUM_PORTS*gi +: NUM_PORTS] = grant;
    end

    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_in
      logic pop;
      always_comb begin
        pop = 1'b0;
        for (int o = 0; o < NUM_PORTS; o++) begin
          pop = pop | grant_flat[NUM_PORTS*o + gi];
        end
      end
      assign in_pop[gi] = pop & ~rst;
    end
  endgenerate

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: per-input flit queues feed the DUT and a
// packet-level model predicts grants, pops, locks and lock errors every cycle.
module tb_switch_allocator;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_valid, req_is_head, req_is_tail, buffer_on_out;
  logic [14:0] req_port;
  logic [4:0]  out_valid, in_pop, out_locked, lock_err;
  logic [14:0] out_sel;

  switch_allocator #(.NUM_PORTS(5), .PORT_W(3), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_port(req_port),
    .req_is_head(req_is_head), .req_is_tail(req_is_tail), .buffer_on_out(buffer_on_out),
    .out_valid(out_valid), .out_sel(out_sel), .in_pop(in_pop),
    .out_locked(out_locked), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  // Flit encoding in the queues: [2:0] port, bit 3 head, bit 4 tail.
  int fifo [5][64];
  int rd [5];
  int wr [5];
  logic [4:0] stall;

  int m_owner [5];
  int m_rr    [5];
  int m_cnt   [5];
  bit m_err   [5];
  int n_owner [5];
  int n_rr    [5];
  int n_cnt   [5];
  bit n_err   [5];
  logic [4:0]  e_valid, e_pop, e_locked, e_err;
  logic [14:0] e_sel;
  logic [4:0]  last_valid, last_pop, last_locked;
  logic [14:0] last_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_pkt(input int i, input int port, input int len);
    for (int f = 0; f < len; f++) begin
      fifo[i][wr[i]] = port + ((f == 0) ? 8 : 0) + ((f == len - 1) ? 16 : 0);
      wr[i]++;
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < 5; o++) begin
      m_owner[o] = -1; m_rr[o] = 0; m_cnt[o] = 0; m_err[o] = 1'b0;
    end
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < 5; i++) begin rd[i] = 0; wr[i] = 0; end
  endtask

  task automatic drive();
    int fl;
    for (int i = 0; i < 5; i++) begin
      if (rd[i] < wr[i] && !stall[i]) begin
        fl = fifo[i][rd[i]];
        req_valid[i] = 1'b1;
        req_port[3*i +: 3] = fl[2:0];
        req_is_head[i] = fl[3];
        req_is_tail[i] = fl[4];
      end else begin
        req_valid[i] = 1'b0;
        req_port[3*i +: 3] = 3'd0;
        req_is_head[i] = 1'b0;
        req_is_tail[i] = 1'b0;
      end
    end
  endtask

  // Packet-level rules: idle outputs pick the next head flit after the last winner,
  // locked outputs follow only their owner until its tail flit goes through.
  task automatic model_eval();
    int g, w, p;
    e_valid = '0; e_pop = '0; e_sel = '0; e_locked = '0; e_err = '0;
    for (int o = 0; o < 5; o++) begin
      n_owner[o] = m_owner[o]; n_rr[o] = m_rr[o]; n_cnt[o] = m_cnt[o]; n_err[o] = m_err[o];
      e_locked[o] = (m_owner[o] >= 0);
      e_err[o] = m_err[o];
      g = -1;
      if (m_owner[o] < 0) begin
        n_cnt[o] = 0;
        if (buffer_on_out[o]) begin
          for (int k = 0; k < 5; k++) begin
            w = (m_rr[o] + k) % 5;
            p = int'(req_port[3*w +: 3]);
            if (g < 0 && req_valid[w] && p == o && req_is_head[w]) g = w;
          end
        end
        if (g >= 0) begin
          n_rr[o] = (g + 1) % 5;
          n_owner[o] = req_is_tail[g] ? -1 : g;
        end
      end else begin
        w = m_owner[o];
        p = int'(req_port[3*w +: 3]);
        if (req_valid[w] && p == o && buffer_on_out[o]) g = w;
        if (g >= 0) begin
          n_cnt[o] = 0;
          if (req_is_tail[w]) begin
            n_owner[o] = -1;
            n_rr[o] = (w + 1) % 5;
          end
        end else begin
          n_cnt[o] = (m_cnt[o] + 1 > TO) ? TO : m_cnt[o] + 1;
          if (n_cnt[o] == TO) n_err[o] = 1'b1;
        end
      end
      if (g >= 0) begin
        e_valid[o] = 1'b1;
        e_sel[3*o +: 3] = g[2:0];
        e_pop[g] = 1'b1;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive();
      #1;
      if (rst) begin
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pop", 32'(in_pop), 32'd0);
        chk("rst_locked", 32'(out_locked), 32'd0);
        chk("rst_err", 32'(lock_err), 32'd0);
        e_pop = '0;
      end else begin
        model_eval();
        chk("valid", 32'(out_valid), 32'(e_valid));
        chk("pop", 32'(in_pop), 32'(e_pop));
        chk("locked", 32'(out_locked), 32'(e_locked));
        chk("lock_err", 32'(lock_err), 32'(e_err));
        for (int o = 0; o < 5; o++)
          if (e_valid[o]) chk($sformatf("sel%0d", o), 32'(out_sel[3*o +: 3]), 32'(e_sel[3*o +: 3]));
      end
      $display("cyc %0d rst=%0b req=%b valid=%b sel=%h pop=%b locked=%b err=%b",
               cyc, rst, req_valid, out_valid, out_sel, in_pop, out_locked, lock_err);
      last_valid = out_valid; last_sel = out_sel; last_pop = in_pop; last_locked = out_locked;
      @(posedge clk);
      if (rst) begin
        model_reset();
      end else begin
        for (int o = 0; o < 5; o++) begin
          m_owner[o] = n_owner[o]; m_rr[o] = n_rr[o]; m_cnt[o] = n_cnt[o]; m_err[o] = n_err[o];
        end
        for (int i = 0; i < 5; i++) if (e_pop[i]) rd[i]++;
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = '0; buffer_on_out = 5'h1F;
    req_valid = '0; req_port = '0; req_is_head = '0; req_is_tail = '0;
    clear_fifos();
    model_reset();
    // Reset with every input requesting; N,E,S,W queue 4-flit packets to L.
    for (int i = 0; i < 4; i++) push_pkt(i, 4, 4);
    push_pkt(4, 0, 1);
    @(negedge clk);
    run(2);
    rst = 1'b0;

    // Contention for L in round-robin order
    run(1);
    chk("t2_first_sel", 32'(last_sel[14:12]), 32'd0);
    chk("t2_first_valid", 32'(last_valid[4]), 32'd1);
    run(3);
    run(1);
    chk("t2_second_sel", 32'(last_sel[14:12]), 32'd1);
    run(3);
    run(1);
    chk("t2_third_sel", 32'(last_sel[14:12]), 32'd2);
    run(3);
    run(1);
    chk("t2_fourth_sel", 32'(last_sel[14:12]), 32'd3);
    run(3);
    run(1);
    chk("t2_released", 32'(last_locked[4]), 32'd0);

    // Backpressure on a locked output
    push_pkt(1, 4, 4);
    run(2);
    buffer_on_out[4] = 1'b0;
    run(3);
    chk("t3_bp_valid", 32'(last_valid[4]), 32'd0);
    chk("t3_bp_pop", 32'(last_pop), 32'd0);
    chk("t3_bp_locked", 32'(last_locked[4]), 32'd1);
    buffer_on_out[4] = 1'b1;
    run(1);
    chk("t3_resume_valid", 32'(last_valid[4]), 32'd1);
    chk("t3_resume_sel", 32'(last_sel[14:12]), 32'd1);
    run(2);

    // Three independent single-flit packets
    push_pkt(0, 2, 1);
    push_pkt(1, 3, 1);
    push_pkt(4, 0, 1);
    run(1);
    chk("t4_valid", 32'(last_valid), 32'h0D);
    chk("t4_pop", 32'(last_pop), 32'h13);
    run(1);
    chk("t4_locked", 32'(last_locked), 32'd0);

    // Lock timeout on output E owned by W
    push_pkt(3, 1, 3);
    run(1);
    stall[3] = 1'b1;
    run(3);
    chk("t5_err_before", 32'(lock_err[1]), 32'd0);
    run(1);
    chk("t5_err_set", 32'(lock_err[1]), 32'd1);
    stall[3] = 1'b0;
    run(2);
    chk("t5_err_sticky", 32'(lock_err[1]), 32'd1);
    chk("t5_unlocked", 32'(out_locked[1]), 32'd0);

    // Asynchronous reset while output S is locked
    push_pkt(0, 2, 4);
    run(2);
    drive();
    #1;
    chk("t6_locked_before", 32'(out_locked[2]), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_locked", 32'(out_locked[2]), 32'd0);
    chk("t6_async_pop", 32'(in_pop), 32'd0);
    chk("t6_async_err", 32'(lock_err), 32'd0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    clear_fifos();
    model_reset();
    run(1);
    rst = 1'b0;
    push_pkt(2, 2, 1);
    run(3);
    chk("t6_after_reset_idle", 32'(out_locked), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
